lsu_mem_ctrl: RTL and testbench

- Load/store unit between the pipeline MEM stage and the data-memory port.
- Takes one byte-addressed RV32 load/store request per handshake and issues word-addressed accesses to the memory, driving a byte mask and lane-shifted write data.
- Splits word-crossing accesses into two memory accesses.
- Aligns and sign/zero-extends load data, then returns a single response.

---
 rtl/lsu_mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store unit: byte-addressed MEM-stage requests to a word-addressed data port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being split.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [31:0]        buf0_q, buf0_d;
    logic [31:0]        buf1_q, buf1_d;

    logic               req_legal;
    logic               req_trap;
    logic [1:0]         off;
    logic [3:0]         size_mask;
    logic [2:0]         size_bytes;
    logic               crossing;
    logic [7:0]         lane_mask;
    logic [63:0]        lane_wdata;
    logic [ADDR_W-1:0]  word_addr;
    logic [ADDR_W-1:0]  word_addr_next;
    logic [31:0]        load_shift;
    logic [31:0]        load_ext;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

    always_comb begin
        req_legal = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~i_req_we;
            default:                req_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need an even offset, words offset zero; bytes never trap.
    always_comb begin
        req_trap = 1'b0;
        case (i_req_funct3[1:0])
            2'b01:   req_trap = i_req_addr[0];
            2'b10:   req_trap = (i_req_addr[1:0] != 2'b00);
            default: req_trap = 1'b0;
        endcase
    end
`else
    assign req_trap = 1'b0;
`endif

    assign off = addr_q[1:0];

    always_comb begin
        size_mask  = 4'b1111;
        size_bytes = 3'd4;
        case (funct3_q[1:0])
            2'b00: begin size_mask = 4'b0001; size_bytes = 3'd1; end
            2'b01: begin size_mask = 4'b0011; size_bytes = 3'd2; end
            default: begin size_mask = 4'b1111; size_bytes = 3'd4; end
        endcase
    end

    assign crossing = (({1'b0, off} + size_bytes) > 3'd4);

    // Low half of each 8-byte/64-bit window feeds ACC0, high half spills into ACC1.
    assign lane_mask      = {4'b0000, size_mask} << off;
    assign lane_wdata     = {32'h0, wdata_q} << {off, 3'b000};
    assign word_addr      = addr_q[ADDR_W+1:2];
    assign word_addr_next = word_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign load_shift = 32'({buf1_q, buf0_q} >> {off, 3'b000});

    always_comb begin
        load_ext = load_shift;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {24'h0, load_shift[7:0]};
            3'b101:  load_ext = {16'h0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        err_d    = err_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d   = i_req_addr[ADDR_W+1:0];
                    wdata_d  = i_req_wdata;
                    funct3_d = i_req_funct3;
                    we_d     = i_req_we;
                    if (!req_legal || req_trap) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ACC0;
                    end
                end
            end
            S_ACC0: begin
                buf0_d  = i_mem_rdata;
                state_d = crossing ? S_ACC1 : S_RESP;
            end
            S_ACC1: begin
                buf1_d  = i_mem_rdata;
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            buf0_q   <= '0;
            buf1_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            err_q    <= err_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0;
        o_mem_wren  = 1'b0;
        case (state_q)
            S_ACC0: begin
                o_mem_addr  = word_addr;
                o_mem_bmask = lane_mask[3:0];
                o_mem_wdata = lane_wdata[31:0];
                o_mem_wren  = we_q;
            end
            S_ACC1: begin
                o_mem_addr  = word_addr_next;
                o_mem_bmask = lane_mask[7:4];
                o_mem_wdata = lane_wdata[63:32];
                o_mem_wren  = we_q;
            end
            default: begin
                o_mem_addr  = '0;
                o_mem_bmask = 4'b0000;
                o_mem_wdata = 32'h0;
                o_mem_wren  = 1'b0;
            end
        endcase
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_err   = (state_q == S_RESP) && err_q;
    assign o_rsp_rdata = ((state_q == S_RESP) && !err_q && !we_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-masked word memory model.
// Honours LSU_MISALIGN_TRAP_EN when the build defines it.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic              i_req_we = 1'b0;
    logic [2:0]        i_req_funct3 = 3'b000;
    logic [31:0]       i_req_addr = 32'h0;
    logic [31:0]       i_req_wdata = 32'h0;
    logic              o_rsp_valid;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    logic [31:0]       mem [0:DEPTH-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_a = '0;
    logic [31:0]       pl_d = 32'h0;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    int wren_cnt = 0;
    int snap;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .o_mem_wren   (o_mem_wren),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge i_clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (o_mem_wren) begin
            for (int k = 0; k < 4; k++)
                if (o_mem_bmask[k]) mem[o_mem_addr][8*k +: 8] <= o_mem_wdata[8*k +: 8];
        end
    end

    always @(negedge i_clk) begin
        if (o_rsp_valid) rsp_cnt++;
        if (o_mem_wren)  wren_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Presents one request in IDLE and returns in the cycle after the accept edge.
    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        chk("ready_before_req", 32'(o_req_ready), 32'd1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        tick();
        i_req_valid  = 1'b0;
        $display("txn we=%0d f3=%03b addr=0x%08h wdata=0x%08h", we, f3, a, wd);
    endtask

    // Load with expected latency (cycles from accept edge to response).
    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input int lat, input logic [31:0] exp_data, input logic exp_err);
        req(1'b0, f3, a, 32'h0);
        for (int c = 1; c < lat; c++) begin
            chk({tag, "_early"}, 32'(o_rsp_valid), 32'd0);
            tick();
        end
        chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({tag, "_rdata"}, o_rsp_rdata, exp_data);
        chk({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
        tick();
        chk({tag, "_one_pulse"}, 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_bmask", 32'(o_mem_bmask), 32'd0);
        chk("rst_mem_wren", 32'(o_mem_wren), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        i_reset = 1'b0;
        chk("rst_ready", 32'(o_req_ready), 32'd1);

        preload(16'd1, 32'h8001_0000);
        preload(16'd2, 32'hDEAD_BEEF);
        preload(16'd3, 32'h0000_0000);
        preload(16'hFFFF, 32'hAABB_CCDD);
        preload(16'd0, 32'h1111_4455);

        // Aligned word load
        req(1'b0, 3'b010, 32'h8, 32'h0);
        chk("lw8_addr", 32'(o_mem_addr), 32'd2);
        chk("lw8_bmask", 32'(o_mem_bmask), 32'b0000_1111 & 32'h0 | 32'hF);
        chk("lw8_wren", 32'(o_mem_wren), 32'd0);
        chk("lw8_not_ready", 32'(o_req_ready), 32'd0);
        tick();
        chk("lw8_valid", 32'(o_rsp_valid), 32'd1);
        chk("lw8_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
        chk("lw8_err", 32'(o_rsp_err), 32'd0);
        tick();
        chk("lw8_idle", 32'(o_rsp_valid), 32'd0);

        // Byte store into lane 1
        req(1'b1, 3'b000, 32'h5, 32'h0000_00A5);
        chk("sb5_addr", 32'(o_mem_addr), 32'd1);
        chk("sb5_bmask", 32'(o_mem_bmask), 32'b0010);
        chk("sb5_wdata", o_mem_wdata, 32'h0000_A500);
        chk("sb5_wren", 32'(o_mem_wren), 32'd1);
        tick();
        chk("sb5_valid", 32'(o_rsp_valid), 32'd1);
        chk("sb5_rdata", o_rsp_rdata, 32'h0);
        chk("sb5_err", 32'(o_rsp_err), 32'd0);
        tick();
        chk("sb5_mem1", mem[1], 32'h8001_A500);

        load_chk("lbu5", 3'b100, 32'h5, 2, 32'h0000_00A5, 1'b0);
        load_chk("lb5",  3'b000, 32'h5, 2, 32'hFFFF_FFA5, 1'b0);
        load_chk("lh6",  3'b001, 32'h6, 2, 32'hFFFF_8001, 1'b0);
        load_chk("lhu6", 3'b101, 32'h6, 2, 32'h0000_8001, 1'b0);

`ifndef LSU_MISALIGN_TRAP_EN
        // Word store straddling words 1 and 2
        snap = rsp_cnt;
        req(1'b1, 3'b010, 32'h7, 32'h1122_3344);
        chk("sw7_acc0_addr", 32'(o_mem_addr), 32'd1);
        chk("sw7_acc0_bmask", 32'(o_mem_bmask), 32'b1000);
        chk("sw7_acc0_wdata", o_mem_wdata, 32'h4400_0000);
        chk("sw7_acc0_wren", 32'(o_mem_wren), 32'd1);
        tick();
        chk("sw7_acc1_addr", 32'(o_mem_addr), 32'd2);
        chk("sw7_acc1_bmask", 32'(o_mem_bmask), 32'b0111);
        chk("sw7_acc1_wdata", o_mem_wdata, 32'h0011_2233);
        chk("sw7_acc1_wren", 32'(o_mem_wren), 32'd1);
        chk("sw7_acc1_no_rsp", 32'(o_rsp_valid), 32'd0);
        tick();
        chk("sw7_valid", 32'(o_rsp_valid), 32'd1);
        chk("sw7_err", 32'(o_rsp_err), 32'd0);
        tick();
        chk("sw7_mem1", mem[1], 32'h4401_A500);
        chk("sw7_mem2", mem[2], 32'hDE11_2233);
        chk("sw7_rsp_count", 32'(rsp_cnt - snap), 32'd1);

        load_chk("lw7", 3'b010, 32'h7, 3, 32'h1122_3344, 1'b0);
        load_chk("lhu5_misal", 3'b101, 32'h5, 2, 32'h0000_01A5, 1'b0);

        // Word load wrapping from the top word to word 0
        req(1'b0, 3'b010, 32'h0003_FFFE, 32'h0);
        chk("wrap_acc0_addr", 32'(o_mem_addr), 32'hFFFF);
        chk("wrap_acc0_bmask", 32'(o_mem_bmask), 32'b1100);
        tick();
        chk("wrap_acc1_addr", 32'(o_mem_addr), 32'd0);
        chk("wrap_acc1_bmask", 32'(o_mem_bmask), 32'b0011);
        chk("wrap_acc1_wren", 32'(o_mem_wren), 32'd0);
        tick();
        chk("wrap_valid", 32'(o_rsp_valid), 32'd1);
        chk("wrap_rdata", o_rsp_rdata, 32'h4455_AABB);
        tick();
`else
        // Misaligned accesses trap with a one-cycle error response and no write
        snap = wren_cnt;
        req(1'b1, 3'b010, 32'h7, 32'h1122_3344);
        chk("sw7_trap_valid", 32'(o_rsp_valid), 32'd1);
        chk("sw7_trap_err", 32'(o_rsp_err), 32'd1);
        chk("sw7_trap_rdata", o_rsp_rdata, 32'h0);
        tick();
        chk("sw7_trap_nowrite", 32'(wren_cnt - snap), 32'd0);
        chk("sw7_trap_mem1", mem[1], 32'h8001_A500);
        chk("sw7_trap_mem2", mem[2], 32'hDEAD_BEEF);
        load_chk("lhu5_trap", 3'b101, 32'h5, 1, 32'h0, 1'b1);
        load_chk("wrap_trap", 3'b010, 32'h0003_FFFE, 1, 32'h0, 1'b1);
`endif

        // Illegal funct3 encodings
        snap = wren_cnt;
        load_chk("ill_011", 3'b011, 32'h8, 1, 32'h0, 1'b1);
        req(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);
        chk("ill_sbu_valid", 32'(o_rsp_valid), 32'd1);
        chk("ill_sbu_err", 32'(o_rsp_err), 32'd1);
        chk("ill_sbu_rdata", o_rsp_rdata, 32'h0);
        tick();
        chk("ill_no_wren", 32'(wren_cnt - snap), 32'd0);

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset during the second half of a split store
        snap = rsp_cnt;
        req(1'b1, 3'b010, 32'hB, 32'h5566_7788);
        chk("rsw_acc0_bmask", 32'(o_mem_bmask), 32'b1000);
        chk("rsw_acc0_wdata", o_mem_wdata, 32'h8800_0000);
        tick();
        chk("rsw_acc1_addr", 32'(o_mem_addr), 32'd3);
        chk("rsw_acc1_wdata", o_mem_wdata, 32'h0055_6677);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rsw_ready", 32'(o_req_ready), 32'd1);
        chk("rsw_no_valid", 32'(o_rsp_valid), 32'd0);
        chk("rsw_wren_off", 32'(o_mem_wren), 32'd0);
        tick();
        tick();
        chk("rsw_no_rsp", 32'(rsp_cnt - snap), 32'd0);
        chk("rsw_first_half", mem[2], 32'h8811_2233);
        load_chk("post_rst_lw8", 3'b010, 32'h8, 2, 32'h8811_2233, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
